// File: rtl/ccsds_rand_pkg.sv
// ---------------------------------------------------------------------------
// ccsds_rand_pkg
// Shared definitions for the CCSDS dual-LFSR (x, y) symbol scrambler:
//   - 18-bit LFSR state width and the packed (x, y) state struct
//   - default reseed values
//   - feedback taps and Q-mask taps, expressed as bit masks
//   - lfsr_step : advance an (x, y) state by one symbol
//   - lfsr_mask : 2-bit {Q, I} scrambling mask of an (x, y) state
// ---------------------------------------------------------------------------
package ccsds_rand_pkg;

   localparam int STATE_W = 18;

   typedef logic [STATE_W-1:0] state_t;

   typedef struct packed {
      state_t x;
      state_t y;
   } lfsr_t;

   localparam state_t DEF_X_SEED = 18'h00001;
   localparam state_t DEF_Y_SEED = 18'h3FFFF;

   // Feedback taps: x uses bits 7,0; y uses bits 10,7,5,0.
   localparam state_t X_FB_TAPS  = 18'h00081;
   localparam state_t Y_FB_TAPS  = 18'h004A1;

   // Q-mask taps: x bits 4,6,15; y bits 5,6,8..15.
   localparam state_t X_Q_TAPS   = 18'h08050;
   localparam state_t Y_Q_TAPS   = 18'h0FF60;

   // One step: shift right, feedback XOR enters at the MSB.
   function automatic lfsr_t lfsr_step(input lfsr_t s);
      lfsr_t n;
      n.x = {^(s.x & X_FB_TAPS), s.x[STATE_W-1:1]};
      n.y = {^(s.y & Y_FB_TAPS), s.y[STATE_W-1:1]};
      return n;
   endfunction

   // Mask packed as {Q, I}, matching the symbol packing on the data ports.
   function automatic logic [1:0] lfsr_mask(input lfsr_t s);
      return {(^(s.x & X_Q_TAPS)) ^ (^(s.y & Y_Q_TAPS)), s.x[0] ^ s.y[0]};
   endfunction

endpackage

// File: rtl/ccsds_scrambler_gold_advance.sv
// ---------------------------------------------------------------------------
// gold_advance
// Combinational N-step advance of the (x, y) LFSR pair. Symbol k's mask is
// taken from the input state advanced k steps; the output state is the input
// advanced N steps.
// Ports:
//   i_state  (x, y) state at the start of the beat
//   o_state  (x, y) state after N steps
//   o_mask   N {Q, I} masks, symbol k at bits [2k+1:2k]
// ---------------------------------------------------------------------------
module gold_advance
   import ccsds_rand_pkg::*;
#(
   parameter int N = 1
) (
   input  lfsr_t            i_state,
   output lfsr_t            o_state,
   output logic [2*N-1:0]   o_mask
);

   lfsr_t w_walk;

   // NOTE: every signal written in always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      w_walk = i_state;
      o_mask = '0;
      for (int k = 0; k < N; k++) begin
         o_mask[2*k +: 2] = lfsr_mask(w_walk);
         w_walk           = lfsr_step(w_walk);
      end
      o_state = w_walk;
   end

endmodule

// File: rtl/ccsds_scrambler.sv
// ---------------------------------------------------------------------------
// ccsds_scrambler
// CCSDS dual-LFSR symbol scrambler, LANES complex symbols per beat, with a
// single-register valid/ready output stage (latency 1).
// Parameters:
//   LANES      symbols per beat (1..8)
//   FRAME_LEN  symbols per frame before automatic reseed (multiple of LANES)
//   X_SEED     x-register reseed value (nonzero)
//   Y_SEED     y-register reseed value (nonzero)
// Ports:
//   i_clk, i_reset     clock, asynchronous active-high reset
//   i_valid, o_ready   input handshake (accept = i_valid && o_ready)
//   i_data             input symbols, symbol k at [2k+1:2k] = {Q, I}
//   i_sof              beat starts a frame, forces reseed
//   i_bypass           pass data unscrambled, sequence still advances
//   o_valid, i_ready   output handshake
//   o_data             scrambled symbols, same packing as i_data
//   o_sof              output beat is the first of a frame
// ---------------------------------------------------------------------------
module ccsds_scrambler
   import ccsds_rand_pkg::*;
#(
   parameter int     LANES     = 1,
   parameter int     FRAME_LEN = 8160,
   parameter state_t X_SEED    = DEF_X_SEED,
   parameter state_t Y_SEED    = DEF_Y_SEED
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [2*LANES-1:0] i_data,
   input  logic               i_sof,
   input  logic               i_bypass,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [2*LANES-1:0] o_data,
   output logic               o_sof
);

   localparam int CNT_W = $clog2(FRAME_LEN + 1);
   typedef logic [CNT_W-1:0] cnt_t;
   localparam cnt_t  C_LANES = cnt_t'(LANES);
   localparam cnt_t  C_FRAME = cnt_t'(FRAME_LEN);
   localparam lfsr_t C_SEED  = '{x: X_SEED, y: Y_SEED};

   lfsr_t              r_state;
   cnt_t               r_count;
   logic               r_valid;
   logic               r_sof;
   logic [2*LANES-1:0] r_data;

   logic               w_accept;
   logic               w_reseed;
   lfsr_t              w_base;
   lfsr_t              w_next;
   logic [2*LANES-1:0] w_mask;

   assign o_ready  = !r_valid || i_ready;
   assign w_accept = i_valid && o_ready;

   // An explicit i_sof and a full-frame wrap collapse into one reseed: the
   // beat's masks come from the seeds either way.
   assign w_reseed = i_sof || (r_count == C_FRAME);
   assign w_base   = w_reseed ? C_SEED : r_state;

   gold_advance #(.N(LANES)) u_advance (
      .i_state (w_base),
      .o_state (w_next),
      .o_mask  (w_mask)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order. All registers
   // here are plain flops (no memory arrays), so all of them are reset.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= C_SEED;
         r_count <= '0;
         r_valid <= 1'b0;
         r_sof   <= 1'b0;
         r_data  <= '0;
      end else if (w_accept) begin
         r_state <= w_next;
         r_count <= w_reseed ? C_LANES : r_count + C_LANES;
         r_valid <= 1'b1;
         r_sof   <= w_reseed;
         r_data  <= i_bypass ? i_data : (i_data ^ w_mask);
      end else if (i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_sof   = r_sof;
   assign o_data  = r_data;

endmodule

// File: tb/tb_ccsds_scrambler.sv
// ---------------------------------------------------------------------------
// tb_ccsds_scrambler
// Directed bench for ccsds_scrambler. dut_a: LANES=1, FRAME_LEN=4.
// dut_b: LANES=4, default FRAME_LEN. Expected masks are hand-derived from the
// default seeds: sequence starts 00,01,01,01,01,11,01,11,01 ({Q,I}).
// ---------------------------------------------------------------------------
module tb_ccsds_scrambler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // ---------------- dut_a ----------------
   logic       a_reset, a_valid, a_oready, a_sof, a_bypass;
   logic       a_ovalid, a_iready, a_osof;
   logic [1:0] a_data, a_odata;

   ccsds_scrambler #(.LANES(1), .FRAME_LEN(4)) dut_a (
      .i_clk    (clk),
      .i_reset  (a_reset),
      .i_valid  (a_valid),
      .o_ready  (a_oready),
      .i_data   (a_data),
      .i_sof    (a_sof),
      .i_bypass (a_bypass),
      .o_valid  (a_ovalid),
      .i_ready  (a_iready),
      .o_data   (a_odata),
      .o_sof    (a_osof)
   );

   // ---------------- dut_b ----------------
   logic       b_reset, b_valid, b_oready, b_sof, b_bypass;
   logic       b_ovalid, b_iready, b_osof;
   logic [7:0] b_data, b_odata;

   ccsds_scrambler #(.LANES(4)) dut_b (
      .i_clk    (clk),
      .i_reset  (b_reset),
      .i_valid  (b_valid),
      .o_ready  (b_oready),
      .i_data   (b_data),
      .i_sof    (b_sof),
      .i_bypass (b_bypass),
      .o_valid  (b_ovalid),
      .i_ready  (b_iready),
      .o_data   (b_odata),
      .o_sof    (b_osof)
   );

   typedef struct {
      logic       sof;
      logic       byp;
      logic [1:0] data;
      logic [1:0] exp_data;
      logic       exp_sof;
   } vec_t;

   vec_t       tbl [15];
   logic [1:0] m   [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic reset_a();
      a_reset = 1'b1; a_valid = 1'b0; a_sof = 1'b0; a_bypass = 1'b0;
      a_data = 2'b00; a_iready = 1'b1;
      @(posedge clk); #1;
      a_reset = 1'b0;
   endtask

   task automatic beat_a(input logic sof, input logic byp, input logic [1:0] d);
      a_valid = 1'b1; a_sof = sof; a_bypass = byp; a_data = d;
      @(posedge clk); #1;
   endtask

   task automatic beat_b(input logic sof, input logic [7:0] d);
      b_valid = 1'b1; b_sof = sof; b_bypass = 1'b0; b_data = d;
      @(posedge clk); #1;
   endtask

   initial begin
      m[0] = 2'b00; m[1] = 2'b01; m[2] = 2'b01; m[3] = 2'b01; m[4] = 2'b01;
      m[5] = 2'b11; m[6] = 2'b01; m[7] = 2'b11; m[8] = 2'b01;

      //            sof   byp   data   exp    exp_sof
      tbl[0]  = '{1'b1, 1'b0, 2'b00, 2'b00, 1'b1};  // seed mask
      tbl[1]  = '{1'b0, 1'b0, 2'b00, 2'b01, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 2'b00, 2'b01, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 2'b11, 2'b10, 1'b0};  // counter reaches 4
      tbl[4]  = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b1};  // automatic wrap
      tbl[5]  = '{1'b0, 1'b0, 2'b10, 2'b11, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 2'b01, 2'b01, 1'b1};  // mid-frame sof
      tbl[7]  = '{1'b0, 1'b0, 2'b00, 2'b01, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 2'b00, 2'b01, 1'b0};
      tbl[9]  = '{1'b0, 1'b0, 2'b00, 2'b01, 1'b0};  // counter reaches 4
      tbl[10] = '{1'b1, 1'b1, 2'b10, 2'b10, 1'b1};  // sof + wrap, bypass
      tbl[11] = '{1'b0, 1'b1, 2'b01, 2'b01, 1'b0};  // bypass
      tbl[12] = '{1'b0, 1'b0, 2'b00, 2'b01, 1'b0};  // third mask
      tbl[13] = '{1'b0, 1'b0, 2'b00, 2'b01, 1'b0};
      tbl[14] = '{1'b0, 1'b0, 2'b11, 2'b11, 1'b1};  // wrap

      b_reset = 1'b1; b_valid = 1'b0; b_sof = 1'b0; b_bypass = 1'b0;
      b_data = 8'h00; b_iready = 1'b1;

      // ---- reset state ----
      reset_a();
      check("reset o_valid", 32'(a_ovalid), 32'h0);
      check("reset o_sof",   32'(a_osof),   32'h0);
      check("reset o_data",  32'(a_odata),  32'h0);
      check("reset o_ready", 32'(a_oready), 32'h1);

      // ---- table-driven vectors ----
      for (int i = 0; i < 15; i++) begin
         beat_a(tbl[i].sof, tbl[i].byp, tbl[i].data);
         check($sformatf("tbl[%0d] o_data", i),  32'(a_odata),  32'(tbl[i].exp_data));
         check($sformatf("tbl[%0d] o_sof", i),   32'(a_osof),   32'(tbl[i].exp_sof));
         check($sformatf("tbl[%0d] o_valid", i), 32'(a_ovalid), 32'h1);
      end

      // ---- no beat with i_ready high clears o_valid ----
      a_valid = 1'b0;
      @(posedge clk); #1;
      check("idle o_valid", 32'(a_ovalid), 32'h0);

      // ---- frame wrap after reset: 9 beats, no i_sof ----
      reset_a();
      for (int i = 0; i < 9; i++) begin
         beat_a(1'b0, 1'b0, 2'b00);
         check($sformatf("wrap[%0d] o_data", i), 32'(a_odata), 32'(m[i % 4]));
         check($sformatf("wrap[%0d] o_sof", i),  32'(a_osof),  32'((i == 4) || (i == 8)));
      end

      // ---- back-pressure: 5 stalled cycles ----
      reset_a();
      beat_a(1'b1, 1'b0, 2'b00);
      check("stall first o_data", 32'(a_odata), 32'(m[0]));
      a_iready = 1'b0; a_sof = 1'b0; a_data = 2'b00;
      #1;
      check("stall o_ready", 32'(a_oready), 32'h0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check($sformatf("stall[%0d] o_data", i),  32'(a_odata),  32'(m[0]));
         check($sformatf("stall[%0d] o_sof", i),   32'(a_osof),   32'h1);
         check($sformatf("stall[%0d] o_valid", i), 32'(a_ovalid), 32'h1);
         check($sformatf("stall[%0d] o_ready", i), 32'(a_oready), 32'h0);
      end
      a_iready = 1'b1;
      #1;
      check("release o_ready", 32'(a_oready), 32'h1);
      @(posedge clk); #1;
      check("release o_data", 32'(a_odata), 32'(m[1]));
      check("release o_sof",  32'(a_osof),  32'h0);
      beat_a(1'b0, 1'b0, 2'b00);
      check("post stall beat2", 32'(a_odata), 32'(m[2]));
      beat_a(1'b0, 1'b0, 2'b11);
      check("post stall beat3", 32'(a_odata), 32'(m[3] ^ 2'b11));

      // ---- asynchronous reset mid-frame ----
      reset_a();
      beat_a(1'b1, 1'b0, 2'b00);
      beat_a(1'b0, 1'b0, 2'b00);
      beat_a(1'b0, 1'b0, 2'b00);
      check("pre reset o_data", 32'(a_odata), 32'(m[2]));
      a_data = 2'b00; a_sof = 1'b0;
      #2 a_reset = 1'b1;
      #1;
      check("async reset o_valid", 32'(a_ovalid), 32'h0);
      check("async reset o_data",  32'(a_odata),  32'h0);
      a_reset = 1'b0;
      @(posedge clk); #1;
      check("after reset o_data", 32'(a_odata), 32'(m[0]));
      check("after reset o_sof",  32'(a_osof),  32'h0);
      beat_a(1'b0, 1'b0, 2'b00);
      check("after reset beat1", 32'(a_odata), 32'(m[1]));
      a_valid = 1'b0;

      // ---- LANES=4 ----
      @(posedge clk); #1;
      b_reset = 1'b0;
      check("b reset o_valid", 32'(b_ovalid), 32'h0);
      beat_b(1'b1, 8'h00);
      check("b beat0 o_data[5:0]", 32'(b_odata[5:0]), 32'h14);
      check("b beat0 vs 1-lane", 32'(b_odata), 32'({m[3], m[2], m[1], m[0]}));
      check("b beat0 o_sof", 32'(b_osof), 32'h1);
      beat_b(1'b0, 8'h00);
      check("b beat1 o_data", 32'(b_odata), 32'({m[7], m[6], m[5], m[4]}));
      check("b beat1 o_sof",  32'(b_osof),  32'h0);
      beat_b(1'b1, 8'hFF);
      check("b resof o_data", 32'(b_odata), 32'h0AB);
      check("b resof o_sof",  32'(b_osof),  32'h1);
      b_valid = 1'b0;
      @(posedge clk); #1;
      check("b idle o_valid", 32'(b_ovalid), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
